// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the convolution tile scheduler:
// layer-parameter packet layout, FSM state encoding and skew-drain length.
package conv_sched_pkg;

    localparam int SCHED_CW      = 16;
    localparam int SCHED_ARRAY_H = 4;
    localparam int SCHED_ARRAY_W = 4;

    // Cycles needed to flush the diagonal skew out of an h x w systolic array.
    function automatic int drain_cycles(input int h, input int w);
        return h + w - 1;
    endfunction

    localparam int SCHED_DRAIN_LEN = drain_cycles(SCHED_ARRAY_H, SCHED_ARRAY_W);

    typedef struct packed {
        logic [SCHED_CW-1:0] ox0;
        logic [SCHED_CW-1:0] oy0;
        logic [SCHED_CW-1:0] fx;
        logic [SCHED_CW-1:0] fy;
        logic [SCHED_CW-1:0] ic1;
        logic [SCHED_CW-1:0] oc1;
        logic [SCHED_CW-1:0] ox1;
        logic [SCHED_CW-1:0] oy1;
    } conv_sched_params_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_BANKS = 3'd1,
        ST_SWITCH     = 3'd2,
        ST_LOAD_W     = 3'd3,
        ST_COMPUTE    = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_OUTPUT     = 3'd6,
        ST_DONE       = 3'd7
    } sched_state_e;

endpackage

// File: rtl/conv_tile_scheduler_counter.sv
// Loadable down-counter used to time scheduler phases; tc_o is high while
// the count sits at zero, i.e. during the last cycle of the phase.
module sched_phase_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != {WIDTH{1'b0}})) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign tc_o = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/conv_tile_scheduler.sv
// Moore controller sequencing one convolution layer through the
// weight-stationary systolic datapath, tile by tile.
module conv_tile_scheduler
    import conv_sched_pkg::*;
#(
    parameter int COUNTER_WIDTH = SCHED_CW,
    parameter int ARRAY_HEIGHT  = SCHED_ARRAY_H,
    parameter int ARRAY_WIDTH   = SCHED_ARRAY_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [8*COUNTER_WIDTH-1:0] params_dat,
    input  logic                       params_vld,
    output logic                       params_rdy,
    input  logic                       ifmap_bank_full,
    input  logic                       weight_bank_full,
    output logic                       ifmap_switch,
    output logic                       weight_switch,
    output logic                       weight_load_en,
    output logic                       compute_en,
    output logic                       first_acc,
    output logic                       ofmap_wen,
    input  logic                       ofmap_stall,
    output logic                       busy,
    output logic                       done
);

    localparam int W = COUNTER_WIDTH;
    localparam logic [W-1:0] LOAD_LEN_M1  = W'(ARRAY_HEIGHT - 1);
    localparam logic [W-1:0] DRAIN_LEN_M1 = W'(drain_cycles(ARRAY_HEIGHT, ARRAY_WIDTH) - 1);
    localparam logic [W-1:0] ONE          = W'(1);
    localparam logic [W-1:0] ZERO         = {W{1'b0}};

    logic [W-1:0] f_ox0, f_oy0, f_fx, f_fy, f_ic1, f_oc1, f_ox1, f_oy1;
    assign f_ox0 = params_dat[8*W-1 -: W];
    assign f_oy0 = params_dat[7*W-1 -: W];
    assign f_fx  = params_dat[6*W-1 -: W];
    assign f_fy  = params_dat[5*W-1 -: W];
    assign f_ic1 = params_dat[4*W-1 -: W];
    assign f_oc1 = params_dat[3*W-1 -: W];
    assign f_ox1 = params_dat[2*W-1 -: W];
    assign f_oy1 = params_dat[W-1:0];

    sched_state_e state_q, state_d;
    logic [W-1:0] npix_q, nw_q, ntile_q, oc1_q;
    logic [W-1:0] tile_cnt_q, oc_cnt_q, w_cnt_q;

    logic         any_zero_s;
    logic         phase_load_s, phase_en_s, phase_tc_s;
    logic [W-1:0] phase_val_s;
    logic         pix_load_s, pix_en_s, pix_tc_s;
    logic         wr_s;

    assign any_zero_s = (f_ox0 == ZERO) || (f_oy0 == ZERO) || (f_fx == ZERO) ||
                        (f_fy == ZERO)  || (f_ic1 == ZERO) || (f_oc1 == ZERO) ||
                        (f_ox1 == ZERO) || (f_oy1 == ZERO);

    // A write only happens in OUTPUT when downstream has room.
    assign wr_s = (state_q == ST_OUTPUT) && !ofmap_stall;

    // Next-state selection and phase-counter reloads on every state change.
    always_comb begin
        state_d      = state_q;
        phase_load_s = 1'b0;
        phase_val_s  = ZERO;
        pix_load_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (params_vld) begin
                    state_d = any_zero_s ? ST_DONE : ST_WAIT_BANKS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BANKS: begin
                if (ifmap_bank_full && ((tile_cnt_q != ZERO) || weight_bank_full)) begin
                    state_d = ST_SWITCH;
                end else begin
                    state_d = ST_WAIT_BANKS;
                end
            end
            ST_SWITCH: state_d = ST_LOAD_W;
            ST_LOAD_W: begin
                if (phase_tc_s) begin
                    state_d = ST_COMPUTE;
                end else begin
                    state_d = ST_LOAD_W;
                end
            end
            ST_COMPUTE: begin
                if (!phase_tc_s) begin
                    state_d = ST_COMPUTE;
                end else if (w_cnt_q < nw_q - ONE) begin
                    state_d = ST_LOAD_W;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (phase_tc_s) begin
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_OUTPUT: begin
                if (!(wr_s && pix_tc_s)) begin
                    state_d = ST_OUTPUT;
                end else if (oc_cnt_q < oc1_q - ONE) begin
                    state_d = ST_LOAD_W;
                end else if (tile_cnt_q < ntile_q - ONE) begin
                    state_d = ST_WAIT_BANKS;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        phase_load_s = (state_d != state_q);
        case (state_d)
            ST_LOAD_W:  phase_val_s = LOAD_LEN_M1;
            ST_COMPUTE: phase_val_s = npix_q - ONE;
            ST_DRAIN:   phase_val_s = DRAIN_LEN_M1;
            default:    phase_val_s = ZERO;
        endcase
        pix_load_s = (state_d == ST_OUTPUT) && (state_q != ST_OUTPUT);
    end

    assign phase_en_s = (state_q == ST_LOAD_W) || (state_q == ST_COMPUTE) ||
                        (state_q == ST_DRAIN);
    assign pix_en_s   = wr_s;

    sched_phase_counter #(.WIDTH(W)) u_phase_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (phase_load_s),
        .load_val_i (phase_val_s),
        .en_i       (phase_en_s),
        .tc_o       (phase_tc_s)
    );

    sched_phase_counter #(.WIDTH(W)) u_pix_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pix_load_s),
        .load_val_i (npix_q - ONE),
        .en_i       (pix_en_s),
        .tc_o       (pix_tc_s)
    );

    // State, captured layer geometry and the weight/oc/tile loop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            npix_q     <= ZERO;
            nw_q       <= ZERO;
            ntile_q    <= ZERO;
            oc1_q      <= ZERO;
            tile_cnt_q <= ZERO;
            oc_cnt_q   <= ZERO;
            w_cnt_q    <= ZERO;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && params_vld) begin
                npix_q     <= f_ox0 * f_oy0;
                nw_q       <= f_fx * f_fy * f_ic1;
                ntile_q    <= f_ox1 * f_oy1;
                oc1_q      <= f_oc1;
                tile_cnt_q <= ZERO;
                oc_cnt_q   <= ZERO;
                w_cnt_q    <= ZERO;
            end else if ((state_q == ST_COMPUTE) && phase_tc_s) begin
                w_cnt_q <= (w_cnt_q < nw_q - ONE) ? w_cnt_q + ONE : ZERO;
            end else if (wr_s && pix_tc_s) begin
                if (oc_cnt_q < oc1_q - ONE) begin
                    oc_cnt_q <= oc_cnt_q + ONE;
                end else begin
                    oc_cnt_q   <= ZERO;
                    tile_cnt_q <= tile_cnt_q + ONE;
                end
            end else begin
                w_cnt_q <= w_cnt_q;
            end
        end
    end

    // Output decode from the registered state; only ofmap_wen sees a live input.
    always_comb begin
        params_rdy     = (state_q == ST_IDLE);
        busy           = (state_q != ST_IDLE);
        ifmap_switch   = (state_q == ST_SWITCH);
        weight_switch  = (state_q == ST_SWITCH) && (tile_cnt_q == ZERO);
        weight_load_en = (state_q == ST_LOAD_W);
        compute_en     = (state_q == ST_COMPUTE);
        first_acc      = (state_q == ST_COMPUTE) && (w_cnt_q == ZERO);
        ofmap_wen      = wr_s;
        done           = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: a cycle table for the single-tile
// layer plus event-count sequences for the multi-cycle corner cases.
module tb_conv_tile_scheduler;
    import conv_sched_pkg::*;

    localparam logic [8:0] O_RDY  = 9'b100000000;
    localparam logic [8:0] O_ISW  = 9'b010000000;
    localparam logic [8:0] O_WSW  = 9'b001000000;
    localparam logic [8:0] O_WL   = 9'b000100000;
    localparam logic [8:0] O_CE   = 9'b000010000;
    localparam logic [8:0] O_FA   = 9'b000001000;
    localparam logic [8:0] O_WEN  = 9'b000000100;
    localparam logic [8:0] O_BUSY = 9'b000000010;
    localparam logic [8:0] O_DONE = 9'b000000001;

    logic clk = 1'b0;
    logic rst_n;
    conv_sched_params_t params_dat;
    logic params_vld, params_rdy, ifmap_bank_full, weight_bank_full;
    logic ifmap_switch, weight_switch, weight_load_en, compute_en, first_acc;
    logic ofmap_wen, ofmap_stall, busy, done;

    always #5 clk = ~clk;

    conv_tile_scheduler dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .params_dat       (params_dat),
        .params_vld       (params_vld),
        .params_rdy       (params_rdy),
        .ifmap_bank_full  (ifmap_bank_full),
        .weight_bank_full (weight_bank_full),
        .ifmap_switch     (ifmap_switch),
        .weight_switch    (weight_switch),
        .weight_load_en   (weight_load_en),
        .compute_en       (compute_en),
        .first_acc        (first_acc),
        .ofmap_wen        (ofmap_wen),
        .ofmap_stall      (ofmap_stall),
        .busy             (busy),
        .done             (done)
    );

    logic [8:0] outs;
    assign outs = {params_rdy, ifmap_switch, weight_switch, weight_load_en,
                   compute_en, first_acc, ofmap_wen, busy, done};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor: counts pulses per scenario and records key cycles.
    int cyc;
    bit mon_en;
    int n_isw, n_wsw, n_wl, n_ce, n_fa, n_wen, n_done, done_cyc, sw_cyc, sw_w;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ifmap_switch) begin
                n_isw  <= n_isw + 1;
                sw_cyc <= cyc;
                sw_w   <= int'(weight_switch);
            end
            if (weight_switch)  n_wsw <= n_wsw + 1;
            if (weight_load_en) n_wl  <= n_wl + 1;
            if (compute_en)     n_ce  <= n_ce + 1;
            if (first_acc)      n_fa  <= n_fa + 1;
            if (ofmap_wen)      n_wen <= n_wen + 1;
            if (done) begin
                n_done <= n_done + 1;
                if (done_cyc < 0) done_cyc <= cyc;
            end
        end
    end

    function automatic conv_sched_params_t mkp(input int ox0, oy0, fx, fy, ic1, oc1, ox1, oy1);
        conv_sched_params_t p;
        p.ox0 = 16'(ox0); p.oy0 = 16'(oy0); p.fx  = 16'(fx);  p.fy  = 16'(fy);
        p.ic1 = 16'(ic1); p.oc1 = 16'(oc1); p.ox1 = 16'(ox1); p.oy1 = 16'(oy1);
        return p;
    endfunction

    // Packet presented in cycle 0; ifmap bank empty in [ifg_lo, ifg_hi),
    // weight bank full only before wdrop, stall high in [st_lo, st_hi).
    task automatic run_scn(input conv_sched_params_t p, input int ncyc, input int ifg_lo,
                           input int ifg_hi, input int wdrop, input int st_lo, input int st_hi);
        mon_en = 1'b0;
        n_isw = 0; n_wsw = 0; n_wl = 0; n_ce = 0; n_fa = 0; n_wen = 0; n_done = 0;
        done_cyc = -1; sw_cyc = -1; sw_w = -1;
        mon_en = 1'b1;
        params_dat = p;
        for (int c = 0; c < ncyc; c++) begin
            cyc              = c;
            params_vld       = (c == 0);
            ifmap_bank_full  = !((c >= ifg_lo) && (c < ifg_hi));
            weight_bank_full = (c < wdrop);
            ofmap_stall      = (c >= st_lo) && (c < st_hi);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        params_vld  = 1'b0;
        ofmap_stall = 1'b0;
        mon_en      = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("reset_outputs", 32'(outs), 32'(O_RDY));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       vld;
        logic       ifull;
        logic       wfull;
        logic       stall;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[25];
    conv_sched_params_t p_one;

    initial begin
        // Single tile 2x2 pixels, params_vld held high to show it is ignored
        // while busy; a stall during DRAIN must have no effect.
        for (int c = 0; c < 25; c++) begin
            tbl[c].vld   = 1'b1;
            tbl[c].ifull = 1'b1;
            tbl[c].wfull = 1'b1;
            tbl[c].stall = (c == 12);
            if (c == 0)                 tbl[c].exp = O_RDY;
            else if (c == 1)            tbl[c].exp = O_BUSY;
            else if (c == 2)            tbl[c].exp = O_ISW | O_WSW | O_BUSY;
            else if (c <= 6)            tbl[c].exp = O_WL | O_BUSY;
            else if (c <= 10)           tbl[c].exp = O_CE | O_FA | O_BUSY;
            else if (c <= 17)           tbl[c].exp = O_BUSY;
            else if (c <= 21)           tbl[c].exp = O_WEN | O_BUSY;
            else if (c == 22)           tbl[c].exp = O_DONE | O_BUSY;
            else if (c == 23)           tbl[c].exp = O_RDY;
            else                        tbl[c].exp = O_BUSY;
        end

        p_one = mkp(2, 2, 1, 1, 1, 1, 1, 1);
        params_dat = p_one;
        params_vld = 1'b0;
        ifmap_bank_full = 1'b0;
        weight_bank_full = 1'b0;
        ofmap_stall = 1'b0;
        mon_en = 1'b0;
        cyc = 0;
        #1;
        do_reset();

        for (int c = 0; c < 25; c++) begin
            params_vld       = tbl[c].vld;
            ifmap_bank_full  = tbl[c].ifull;
            weight_bank_full = tbl[c].wfull;
            ofmap_stall      = tbl[c].stall;
            @(negedge clk);
            chk($sformatf("single_tile_cyc%0d", c), 32'(outs), 32'(tbl[c].exp));
            @(posedge clk);
            #1;
        end
        params_vld = 1'b0;
        ofmap_stall = 1'b0;
        do_reset();

        // Two weight sets back to back, drain only after the last one.
        run_scn(mkp(2, 2, 1, 1, 2, 1, 1, 1), 33, 0, 0, 1000, 0, 0);
        chk("nw2_done_cyc", 32'(done_cyc), 32'd30);
        chk("nw2_wl", 32'(n_wl), 32'd8);
        chk("nw2_ce", 32'(n_ce), 32'd8);
        chk("nw2_first_acc", 32'(n_fa), 32'd4);
        chk("nw2_wen", 32'(n_wen), 32'd4);
        chk("nw2_wsw", 32'(n_wsw), 32'd1);

        // Two tiles, second input bank 10 cycles late, weight bank not refilled.
        run_scn(mkp(2, 2, 1, 1, 1, 1, 2, 1), 56, 3, 32, 3, 0, 0);
        chk("tile2_isw", 32'(n_isw), 32'd2);
        chk("tile2_wsw", 32'(n_wsw), 32'd1);
        chk("tile2_sw_cyc", 32'(sw_cyc), 32'd33);
        chk("tile2_sw_weight", 32'(sw_w), 32'd0);
        chk("tile2_done_cyc", 32'(done_cyc), 32'd53);
        chk("tile2_wen", 32'(n_wen), 32'd8);
        chk("tile2_first_acc", 32'(n_fa), 32'd8);

        // Two output-channel passes reuse the same input bank.
        run_scn(mkp(2, 2, 1, 1, 1, 2, 1, 1), 44, 0, 0, 1000, 0, 0);
        chk("oc2_isw", 32'(n_isw), 32'd1);
        chk("oc2_done_cyc", 32'(done_cyc), 32'd41);
        chk("oc2_first_acc", 32'(n_fa), 32'd8);
        chk("oc2_wen", 32'(n_wen), 32'd8);

        // Three-cycle stall in the middle of OUTPUT.
        run_scn(p_one, 28, 0, 0, 1000, 19, 22);
        chk("stall_wen", 32'(n_wen), 32'd4);
        chk("stall_done_cyc", 32'(done_cyc), 32'd25);

        // Zero field: straight to DONE with no datapath activity.
        run_scn(mkp(2, 2, 0, 1, 1, 1, 1, 1), 5, 0, 0, 1000, 0, 0);
        chk("zero_done_cyc", 32'(done_cyc), 32'd1);
        chk("zero_done_cnt", 32'(n_done), 32'd1);
        chk("zero_activity", 32'(n_isw + n_wsw + n_wl + n_ce + n_wen), 32'd0);

        // Asynchronous reset during COMPUTE, then a fresh layer from tile 0.
        run_scn(p_one, 9, 0, 0, 1000, 0, 0);
        chk("midrst_in_compute", 32'(compute_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", 32'(outs), 32'(O_RDY));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_scn(p_one, 25, 0, 0, 1000, 0, 0);
        chk("midrst_rerun_done", 32'(done_cyc), 32'd22);
        chk("midrst_rerun_wsw", 32'(n_wsw), 32'd1);
        chk("midrst_rerun_wen", 32'(n_wen), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
